// File: rtl/cv32e40p_bitcnt_pipe.sv
// Two-stage pipelined bit counter: popcount, clz, ctz and saturating
// multi-beat accumulated popcount behind valid/ready streams.
`timescale 1ns/1ps
module cv32e40p_bitcnt_pipe #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic             last_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [ACC_W-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int H     = WIDTH / 2;
  localparam int HC_W  = $clog2(H) + 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef struct packed {
    logic [1:0]      mode;
    logic            last;
    logic            zlo;
    logic            zhi;
    logic [HC_W-1:0] pop_lo;
    logic [HC_W-1:0] pop_hi;
    logic [HC_W-1:0] clz_lo;
    logic [HC_W-1:0] clz_hi;
    logic [HC_W-1:0] ctz_lo;
    logic [HC_W-1:0] ctz_hi;
  } s1_t;

  function automatic logic [HC_W-1:0] pop_f(input logic [H-1:0] v);
    logic [HC_W-1:0] c;
    c = '0;
    for (int i = 0; i < H; i++) c = c + HC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [HC_W-1:0] clz_f(input logic [H-1:0] v);
    logic [HC_W-1:0] c;
    logic            hit;
    c   = '0;
    hit = 1'b0;
    for (int i = H - 1; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) c = c + HC_W'(1);
    end
    return c;
  endfunction

  function automatic logic [HC_W-1:0] ctz_f(input logic [H-1:0] v);
    logic [HC_W-1:0] c;
    logic            hit;
    c   = '0;
    hit = 1'b0;
    for (int i = 0; i < H; i++) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) c = c + HC_W'(1);
    end
    return c;
  endfunction

  s1_t              s1_in, s1_d, s1_q;
  logic             s1_valid_d, s1_valid_q;
  logic             valid_o_d, valid_o_q;
  logic [ACC_W-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             acc_ovf_d, acc_ovf_q;
  logic             acc_zero_d, acc_zero_q;

  logic             s2_adv, accept, move;
  logic [CNT_W-1:0] pop, clz, ctz;
  logic             beat_zero;
  logic [ACC_W:0]   sum;
  logic             sat;
  logic [ACC_W-1:0] acc_sum;
  logic [H-1:0]     lo, hi;

  assign s2_adv  = !valid_o_q || ready_i;
  assign ready_o = !s1_valid_q || s2_adv;
  assign accept  = valid_i && ready_o && !flush_i;
  assign move    = s1_valid_q && s2_adv;

  always_comb begin
    lo            = data_i[H-1:0];
    hi            = data_i[WIDTH-1:H];
    s1_in.mode    = mode_i;
    s1_in.last    = last_i;
    s1_in.zlo     = ~|lo;
    s1_in.zhi     = ~|hi;
    s1_in.pop_lo  = pop_f(lo);
    s1_in.pop_hi  = pop_f(hi);
    s1_in.clz_lo  = clz_f(lo);
    s1_in.clz_hi  = clz_f(hi);
    s1_in.ctz_lo  = ctz_f(lo);
    s1_in.ctz_hi  = ctz_f(hi);
  end

  // An all-zero half reports H, so an all-zero operand yields WIDTH.
  always_comb begin
    beat_zero = s1_q.zlo && s1_q.zhi;
    pop = CNT_W'(s1_q.pop_lo) + CNT_W'(s1_q.pop_hi);
    clz = s1_q.zhi ? CNT_W'(H) + CNT_W'(s1_q.clz_lo)
                   : CNT_W'(s1_q.clz_hi);
    ctz = s1_q.zlo ? CNT_W'(H) + CNT_W'(s1_q.ctz_hi)
                   : CNT_W'(s1_q.ctz_lo);
    sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(pop);
    sat     = sum[ACC_W];
    acc_sum = sat ? '1 : sum[ACC_W-1:0];
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    valid_o_d  = valid_o_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    acc_zero_d = acc_zero_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      valid_o_d  = 1'b0;
      acc_d      = '0;
      acc_ovf_d  = 1'b0;
      acc_zero_d = 1'b1;
    end else begin
      if (s2_adv) valid_o_d = 1'b0;
      if (move) begin
        unique case (s1_q.mode)
          2'b00: begin
            valid_o_d = 1'b1;
            result_d  = ACC_W'(pop);
            zero_d    = beat_zero;
            ovf_d     = 1'b0;
          end
          2'b01: begin
            valid_o_d = 1'b1;
            result_d  = ACC_W'(clz);
            zero_d    = beat_zero;
            ovf_d     = 1'b0;
          end
          2'b10: begin
            valid_o_d = 1'b1;
            result_d  = ACC_W'(ctz);
            zero_d    = beat_zero;
            ovf_d     = 1'b0;
          end
          default: begin
            if (s1_q.last) begin
              valid_o_d  = 1'b1;
              result_d   = acc_sum;
              zero_d     = acc_zero_q && beat_zero;
              ovf_d      = acc_ovf_q || sat;
              acc_d      = '0;
              acc_ovf_d  = 1'b0;
              acc_zero_d = 1'b1;
            end else begin
              acc_d      = acc_sum;
              acc_ovf_d  = acc_ovf_q || sat;
              acc_zero_d = acc_zero_q && beat_zero;
            end
          end
        endcase
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_d       = s1_in;
      end else if (move) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      valid_o_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      acc_zero_q <= 1'b1;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      valid_o_q  <= valid_o_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      acc_zero_q <= acc_zero_d;
    end
  end

  assign valid_o  = valid_o_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_cv32e40p_bitcnt_pipe.sv
// Bench for cv32e40p_bitcnt_pipe: directed table, corner sequences and
// random traffic against a queue-based reference model (ACC_W 16 and 6).
`timescale 1ns/1ps
module tb_cv32e40p_bitcnt_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [1:0]  mode_i = '0;

  logic        ready_o, valid_o, zero_o, ovf_o;
  logic [15:0] result_o;
  logic        ready6, valid6, zero6, ovf6;
  logic [5:0]  result6;

  cv32e40p_bitcnt_pipe #(.WIDTH(32), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .mode_i(mode_i), .last_i(last_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o),
    .ovf_o(ovf_o)
  );

  cv32e40p_bitcnt_pipe #(.WIDTH(32), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready6), .data_i(data_i),
    .mode_i(mode_i), .last_i(last_i), .valid_o(valid6),
    .ready_i(ready_i), .result_o(result6), .zero_o(zero6),
    .ovf_o(ovf6)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res16;
    logic        zero;
    logic        ovf16;
    logic [31:0] res6;
    logic        ovf6;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic        last;
    logic        has_out;
    exp_t        e;
  } row_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_chk = 0;
  int     n_err = 0;
  int     out_cnt = 0;
  int     acc_cnt = 0;
  bit     use_model = 1'b0;
  longint m_sum = 0;
  bit     m_zero = 1'b1;
  logic [31:0] last_res;
  logic        hold_q = 1'b0, flush_q = 1'b0;
  logic [15:0] p_res;
  logic        p_zero, p_ovf;
  logic [5:0]  p_res6;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  function automatic int clz_m(input logic [31:0] d);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int ctz_m(input logic [31:0] d);
    int n = 0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  // Accumulation tracked as an unbounded sum; clamping is applied at output.
  task automatic model(input logic [31:0] d, input logic [1:0] m,
                       input logic l);
    exp_t e;
    int   p;
    p = $countones(d);
    e.zero = (d == 0);
    e.ovf16 = 1'b0;
    e.ovf6 = 1'b0;
    if (m == 2'd3) begin
      m_sum += p;
      m_zero = m_zero && (d == 0);
      if (l) begin
        e.res16 = (m_sum > 65535) ? 65535 : 32'(m_sum);
        e.ovf16 = (m_sum > 65535);
        e.res6  = (m_sum > 63) ? 63 : 32'(m_sum);
        e.ovf6  = (m_sum > 63);
        e.zero  = m_zero;
        exp_q.push_back(e);
        m_sum  = 0;
        m_zero = 1'b1;
      end
    end else begin
      e.res16 = (m == 2'd0) ? p : (m == 2'd1) ? clz_m(d) : ctz_m(d);
      e.res6  = e.res16;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q  = 1'b0;
      flush_q = 1'b0;
    end else begin
      if (hold_q && !flush_q) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_res", result_o, p_res);
        chk("hold_zero", zero_o, p_zero);
        chk("hold_ovf", ovf_o, p_ovf);
        chk("hold_res6", result6, p_res6);
      end
      if (valid_o && ready_i) begin
        out_cnt++;
        last_res = result_o;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_res16", result_o, mon_e.res16);
          chk("out_zero", zero_o, mon_e.zero);
          chk("out_ovf16", ovf_o, mon_e.ovf16);
          chk("out_valid6", valid6, 1);
          chk("out_res6", result6, mon_e.res6);
          chk("out_ovf6", ovf6, mon_e.ovf6);
        end
      end
      if (flush_i) begin
        exp_q.delete();
        m_sum  = 0;
        m_zero = 1'b1;
      end else if (valid_i && ready_o) begin
        acc_cnt++;
        if (use_model) model(data_i, mode_i, last_i);
      end
      hold_q  = valid_o && !ready_i;
      flush_q = flush_i;
      p_res   = result_o;
      p_zero  = zero_o;
      p_ovf   = ovf_o;
      p_res6  = result6;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m,
                      input logic l);
    int n = 0;
    valid_i = 1'b1;
    data_i  = d;
    mode_i  = m;
    last_i  = l;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    step();
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  row_t rows[$];
  int   ob, base;

  initial begin
    rows = '{
      '{32'h0000_0000, 2'd0, 0, 1, '{0, 1, 0, 0, 0}},
      '{32'hFFFF_FFFF, 2'd0, 0, 1, '{32, 0, 0, 32, 0}},
      '{32'h8000_0001, 2'd0, 0, 1, '{2, 0, 0, 2, 0}},
      '{32'h0001_0000, 2'd1, 0, 1, '{15, 0, 0, 15, 0}},
      '{32'h0001_0000, 2'd2, 0, 1, '{16, 0, 0, 16, 0}},
      '{32'h0000_0000, 2'd1, 0, 1, '{32, 1, 0, 32, 0}},
      '{32'h0000_0000, 2'd2, 0, 1, '{32, 1, 0, 32, 0}},
      '{32'h8000_0000, 2'd1, 0, 1, '{0, 0, 0, 0, 0}},
      '{32'h8000_0000, 2'd2, 0, 1, '{31, 0, 0, 31, 0}},
      '{32'hFFFF_FFFF, 2'd3, 0, 0, '{0, 0, 0, 0, 0}},
      '{32'hFFFF_FFFF, 2'd3, 0, 0, '{0, 0, 0, 0, 0}},
      '{32'hFFFF_FFFF, 2'd3, 1, 1, '{96, 0, 0, 63, 1}},
      '{32'h0000_0003, 2'd0, 0, 1, '{2, 0, 0, 2, 0}},
      '{32'h0000_0000, 2'd3, 0, 0, '{0, 0, 0, 0, 0}},
      '{32'h0000_0001, 2'd1, 1, 1, '{31, 0, 0, 31, 0}},
      '{32'h0000_0000, 2'd3, 1, 1, '{0, 1, 0, 0, 0}},
      '{32'h0000_000F, 2'd3, 1, 1, '{4, 0, 0, 4, 0}}
    };

    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_zero", zero_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_ready", ready_o, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    use_model = 1'b0;
    foreach (rows[i]) begin
      if (rows[i].has_out) exp_q.push_back(rows[i].e);
      send(rows[i].data, rows[i].mode, rows[i].last);
    end
    wait_drain();

    use_model = 1'b1;
    send(32'h0000_00FF, 2'd0, 1'b0);
    @(negedge clk);
    chk("lat_e0", valid_o, 0);
    @(negedge clk);
    chk("lat_e1", valid_o, 1);
    wait_drain();

    base = acc_cnt;
    ob   = out_cnt;
    ready_i = 1'b0;
    valid_i = 1'b1;
    mode_i  = 2'd0;
    for (int k = 0; k < 6; k++) begin
      data_i = $urandom;
      step();
    end
    valid_i = 1'b0;
    chk("bp_accepted", acc_cnt - base, 2);
    chk("bp_ready_lo", ready_o, 0);
    ready_i = 1'b1;
    #1 chk("bp_ready_comb", ready_o, 1);
    wait_drain();
    repeat (3) step();
    chk("bp_outs", out_cnt - ob, 2);

    send(32'hFFFF_FFFF, 2'd3, 1'b0);
    send(32'hFFFF_FFFF, 2'd3, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    ob = out_cnt;
    send(32'h0000_000F, 2'd3, 1'b1);
    wait_drain();
    repeat (2) step();
    chk("flush_outs", out_cnt - ob, 1);
    chk("flush_res", last_res, 4);

    for (int c = 0; c < 800; c++) begin
      int sel;
      sel     = $urandom_range(0, 9);
      valid_i = ($urandom_range(0, 9) < 7);
      mode_i  = 2'($urandom_range(0, 3));
      last_i  = ($urandom_range(0, 2) == 0);
      ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 59) == 0);
      if (sel == 0) data_i = '0;
      else if (sel == 1) data_i = '1;
      else if (sel == 2) data_i = 32'h1 << $urandom_range(0, 31);
      else data_i = $urandom;
      step();
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    send(32'h0, 2'd3, 1'b1);
    wait_drain();

    ready_i = 1'b0;
    send(32'h0000_0001, 2'd0, 1'b0);
    send(32'h0000_0003, 2'd0, 1'b0);
    step();
    chk("pre_rst_valid", valid_o, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_valid6", valid6, 0);
    chk("async_rst_result", result_o, 0);
    chk("async_rst_ready", ready_o, 1);
    exp_q.delete();
    m_sum  = 0;
    m_zero = 1'b1;
    step();
    rst_n   = 1'b1;
    ready_i = 1'b1;
    step();
    ob = out_cnt;
    send(32'h0000_00F0, 2'd0, 1'b0);
    wait_drain();
    repeat (2) step();
    chk("post_rst_outs", out_cnt - ob, 1);
    chk("post_rst_res", last_res, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
